// File: rtl/io_pkg.sv
// Shared encodings for the button interrupt path: FSM states, the
// button-to-interruptions bit map and the priority helpers.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQUEST = 2'b01,
        SERVICE = 2'b10
    } state_t;

    localparam logic [2:0] INT_BIT_BTN0 = 3'd6;
    localparam logic [2:0] INT_BIT_BTN1 = 3'd5;
    localparam logic [2:0] INT_BIT_BTN2 = 3'd4;
    localparam logic [2:0] INT_BIT_BTN3 = 3'd3;

    localparam logic [3:0] DEFAULT_MASK = 4'b1111;

    // Lowest set index wins; button0 is the highest priority.
    function automatic logic [1:0] prio_index(input logic [3:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] int_bit(input logic [1:0] idx);
        logic [2:0] b;
        case (idx)
            2'd0:    b = INT_BIT_BTN0;
            2'd1:    b = INT_BIT_BTN1;
            2'd2:    b = INT_BIT_BTN2;
            default: b = INT_BIT_BTN3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-facing request/acknowledge/service handshake of the interrupt controller.
interface interrupt_controller_if;
    // int_req stays high with int_vector/interruptions stable until int_ack is
    // seen; interruptions then stays up until int_done closes the service.
    logic       int_req;
    logic [2:0] int_vector;
    logic [7:0] interruptions;
    logic       int_ack;
    logic       int_done;

    modport master (
        output int_req,
        output int_vector,
        output interruptions,
        input  int_ack,
        input  int_done
    );

    modport slave (
        input  int_req,
        input  int_vector,
        input  interruptions,
        output int_ack,
        output int_done
    );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for one raw push-button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // The level only flips after DEBOUNCE_CYCLES consecutive differing edges.
            if (r_sync2 != r_level) begin
                if (r_cnt == LAST_CNT) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/interrupt_controller.sv
// Debounces four buttons, latches rising edges as pending events and serves
// them one at a time to the CPU in fixed priority order.
module interrupt_controller
    import io_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        buttons,
    input  logic                    mask_we,
    input  logic [N_SRC-1:0]        mask_in,
    interrupt_controller_if.master  cpu,
    output logic [N_SRC-1:0]        pending,
    output logic [N_SRC-1:0]        mask,
    output logic [1:0]              fsm_state
);

    logic [N_SRC-1:0] w_level;
    logic [N_SRC-1:0] r_level_d;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] w_pending_next;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] w_elig;
    logic [1:0]       w_win;
    logic [2:0]       w_win_bit;

    state_t     r_state, w_state_next;
    logic [1:0] r_sel, w_sel_next;
    logic       r_req, w_req_next;
    logic [2:0] r_vec, w_vec_next;
    logic [7:0] r_intr, w_intr_next;

    for (genvar g = 0; g < N_SRC; g++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (buttons[g]),
            .o_level(w_level[g])
        );
    end

    assign w_rise    = w_level & ~r_level_d;
    assign w_elig    = r_pending & r_mask;
    assign w_win     = prio_index(w_elig);
    assign w_win_bit = int_bit(w_win);

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_req_next   = r_req;
        w_vec_next   = r_vec;
        w_intr_next  = r_intr;
        w_clr        = '0;
        case (r_state)
            IDLE: begin
                if (|w_elig) begin
                    w_sel_next   = w_win;
                    w_req_next   = 1'b1;
                    w_vec_next   = w_win_bit;
                    w_intr_next  = 8'b1 << w_win_bit;
                    w_state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (cpu.int_ack) begin
                    w_clr[r_sel] = 1'b1;
                    w_req_next   = 1'b0;
                    w_state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (cpu.int_done) begin
                    w_intr_next  = 8'h00;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_intr_next  = 8'h00;
                w_state_next = IDLE;
            end
        endcase
    end

    // A fresh rising edge on the same edge as its ack clear keeps the event.
    assign w_pending_next = (r_pending & ~w_clr) | w_rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_sel     <= 2'd0;
            r_req     <= 1'b0;
            r_vec     <= 3'd0;
            r_intr    <= 8'h00;
            r_pending <= '0;
            r_level_d <= '0;
            r_mask    <= DEFAULT_MASK;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_req     <= w_req_next;
            r_vec     <= w_vec_next;
            r_intr    <= w_intr_next;
            r_pending <= w_pending_next;
            r_level_d <= w_level;
            if (mask_we) r_mask <= mask_in;
        end
    end

    assign cpu.int_req       = r_req;
    assign cpu.int_vector    = r_vec;
    assign cpu.interruptions = r_intr;
    assign pending           = r_pending;
    assign mask              = r_mask;
    assign fsm_state         = r_state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus a randomized run against a behavioural model of the controller.
module tb_interrupt_controller;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic       mask_we = 1'b0;
    logic [3:0] mask_in = 4'b0000;
    logic [3:0] pending;
    logic [3:0] mask;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;

    interrupt_controller_if cpu_if ();

    always #5 clk = ~clk;

    interrupt_controller #(
        .N_SRC          (4),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .buttons  (buttons),
        .mask_we  (mask_we),
        .mask_in  (mask_in),
        .cpu      (cpu_if.master),
        .pending  (pending),
        .mask     (mask),
        .fsm_state(fsm_state)
    );

    // ---------------- behavioural reference model ----------------
    logic [3:0] m_pend, m_mask, m_lvl, m_rise_prev, m_rise, m_clr, m_elig, m_seen;
    logic [3:0] m_hist[$];
    int         m_run[4];
    int         m_phase;   // 0 waiting for an event, 1 request raised, 2 handler running
    bit         m_req;
    logic [2:0] m_vec;
    logic [7:0] m_intr;

    always @(posedge clk) begin
        if (!reset) begin
            m_pend = 4'h0; m_mask = 4'hF; m_lvl = 4'h0; m_rise_prev = 4'h0;
            m_hist = {4'h0, 4'h0};
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_phase = 0; m_req = 0; m_vec = 3'd0; m_intr = 8'h00;
        end else begin
            m_seen = m_hist[m_hist.size() - 2];
            m_hist.push_back(buttons);
            if (m_hist.size() > 3) void'(m_hist.pop_front());
            m_clr = 4'h0;
            m_elig = m_pend & m_mask;
            if (m_phase == 0) begin
                if (m_elig != 4'h0) begin
                    for (int i = 3; i >= 0; i--) if (m_elig[i]) m_vec = 3'(6 - i);
                    m_intr = 8'h01 << m_vec;
                    m_req = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (cpu_if.int_ack) begin
                    m_clr[6 - int'(m_vec)] = 1'b1;
                    m_req = 0; m_phase = 2;
                end
            end else begin
                if (cpu_if.int_done) begin
                    m_intr = 8'h00; m_phase = 0;
                end
            end
            m_pend = (m_pend & ~m_clr) | m_rise_prev;
            if (mask_we) m_mask = mask_in;
            m_rise = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (m_seen[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = m_seen[i];
                        m_rise[i] = m_seen[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise_prev = m_rise;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max_edges, output int edges, output bit seen);
        edges = 0;
        seen = 0;
        while (!seen && edges < max_edges) begin
            step();
            edges++;
            if (cpu_if.int_req === 1'b1) seen = 1;
        end
    endtask

    task automatic ack_pulse();
        cpu_if.int_ack = 1'b1;
        step();
        cpu_if.int_ack = 1'b0;
    endtask

    task automatic done_pulse();
        cpu_if.int_done = 1'b1;
        step();
        cpu_if.int_done = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] v);
        mask_in = v;
        mask_we = 1'b1;
        step();
        mask_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        buttons = 4'b1111;
        step();
        step();
        checks++;
        if ({cpu_if.int_req, cpu_if.int_vector, cpu_if.interruptions} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: req/vec/intr=%h expected 000", {cpu_if.int_req, cpu_if.int_vector, cpu_if.interruptions});
        end
        checks++;
        if (pending !== 4'b0000 || mask !== 4'b1111 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_regs: pending=%b mask=%b state=%b expected 0000 1111 00", pending, mask, fsm_state);
        end
    endtask

    task automatic test_latency();
        int  edges;
        bit  seen;
        logic [2:0] exp_vec[3] = '{3'd5, 3'd4, 3'd3};
        reset = 1'b1;
        wait_req(20, edges, seen);
        checks++;
        if (!seen || edges != D + 4) begin
            errors++;
            $display("FAIL latency: req seen=%0d after %0d edges, expected %0d", seen, edges, D + 4);
        end
        checks++;
        if (cpu_if.int_vector !== 3'd6 || cpu_if.interruptions !== 8'h40) begin
            errors++;
            $display("FAIL latency_vector: vec=%0d intr=%h expected 6 40", cpu_if.int_vector, cpu_if.interruptions);
        end
        ack_pulse();
        checks++;
        if (cpu_if.int_req !== 1'b0 || cpu_if.interruptions !== 8'h40 || pending !== 4'b1110) begin
            errors++;
            $display("FAIL latency_ack: req=%b intr=%h pending=%b expected 0 40 1110", cpu_if.int_req, cpu_if.interruptions, pending);
        end
        done_pulse();
        checks++;
        if (cpu_if.interruptions !== 8'h00 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL latency_done: intr=%h state=%b expected 00 00", cpu_if.interruptions, fsm_state);
        end
        for (int k = 0; k < 3; k++) begin
            wait_req(5, edges, seen);
            checks++;
            if (!seen || edges != 1 || cpu_if.int_vector !== exp_vec[k]) begin
                errors++;
                $display("FAIL drain_order: seen=%0d edges=%0d vec=%0d expected 1 1 %0d", seen, edges, cpu_if.int_vector, exp_vec[k]);
            end
            ack_pulse();
            done_pulse();
        end
        buttons = 4'b0000;
        repeat (12) step();
        checks++;
        if (pending !== 4'b0000 || cpu_if.int_req !== 1'b0) begin
            errors++;
            $display("FAIL release_ignored: pending=%b req=%b expected 0000 0", pending, cpu_if.int_req);
        end
    endtask

    task automatic test_glitch();
        bit any_req = 0;
        buttons = 4'b0010;
        repeat (3) step();
        buttons = 4'b0000;
        repeat (12) begin
            step();
            if (cpu_if.int_req === 1'b1) any_req = 1;
        end
        checks++;
        if (pending !== 4'b0000 || any_req) begin
            errors++;
            $display("FAIL glitch: pending=%b req_seen=%0d expected 0000 0", pending, any_req);
        end
    endtask

    task automatic test_priority();
        int edges;
        bit seen;
        buttons = 4'b1010;
        wait_req(20, edges, seen);
        checks++;
        if (!seen || cpu_if.int_vector !== 3'd5 || cpu_if.interruptions !== 8'h20 || pending !== 4'b1010) begin
            errors++;
            $display("FAIL priority_first: seen=%0d vec=%0d intr=%h pending=%b expected 1 5 20 1010", seen, cpu_if.int_vector, cpu_if.interruptions, pending);
        end
        ack_pulse();
        done_pulse();
        wait_req(5, edges, seen);
        checks++;
        if (!seen || edges != 1 || cpu_if.int_vector !== 3'd3 || cpu_if.interruptions !== 8'h08) begin
            errors++;
            $display("FAIL priority_second: seen=%0d edges=%0d vec=%0d intr=%h expected 1 1 3 08", seen, edges, cpu_if.int_vector, cpu_if.interruptions);
        end
        ack_pulse();
        done_pulse();
        buttons = 4'b0000;
        repeat (12) step();
    endtask

    task automatic test_mask();
        bit any_req = 0;
        write_mask(4'b1110);
        buttons = 4'b0001;
        repeat (12) begin
            step();
            if (cpu_if.int_req === 1'b1) any_req = 1;
        end
        ack_pulse();
        checks++;
        if (pending !== 4'b0001 || any_req || mask !== 4'b1110) begin
            errors++;
            $display("FAIL masked_pending: pending=%b req_seen=%0d mask=%b expected 0001 0 1110", pending, any_req, mask);
        end
        write_mask(4'b1111);
        checks++;
        if (cpu_if.int_req !== 1'b0 || mask !== 4'b1111) begin
            errors++;
            $display("FAIL unmask_edge: req=%b mask=%b expected 0 1111", cpu_if.int_req, mask);
        end
        step();
        checks++;
        if (cpu_if.int_req !== 1'b1 || cpu_if.int_vector !== 3'd6) begin
            errors++;
            $display("FAIL unmask_next: req=%b vec=%0d expected 1 6", cpu_if.int_req, cpu_if.int_vector);
        end
        ack_pulse();
        done_pulse();
        buttons = 4'b0000;
        repeat (12) step();
    endtask

    task automatic test_no_preempt();
        int edges;
        bit seen;
        bit moved = 0;
        buttons = 4'b0100;
        wait_req(20, edges, seen);
        checks++;
        if (!seen || cpu_if.int_vector !== 3'd4) begin
            errors++;
            $display("FAIL preempt_start: seen=%0d vec=%0d expected 1 4", seen, cpu_if.int_vector);
        end
        buttons = 4'b0101;
        repeat (12) begin
            step();
            if (cpu_if.int_vector !== 3'd4 || cpu_if.int_req !== 1'b1) moved = 1;
        end
        done_pulse();
        checks++;
        if (moved || fsm_state !== 2'b01 || cpu_if.int_req !== 1'b1 || pending !== 4'b0101) begin
            errors++;
            $display("FAIL no_preempt: moved=%0d state=%b req=%b pending=%b expected 0 01 1 0101", moved, fsm_state, cpu_if.int_req, pending);
        end
        ack_pulse();
        checks++;
        if (pending !== 4'b0001 || cpu_if.interruptions !== 8'h10 || fsm_state !== 2'b10) begin
            errors++;
            $display("FAIL preempt_ack: pending=%b intr=%h state=%b expected 0001 10 10", pending, cpu_if.interruptions, fsm_state);
        end
        done_pulse();
        wait_req(5, edges, seen);
        checks++;
        if (!seen || edges != 1 || cpu_if.int_vector !== 3'd6) begin
            errors++;
            $display("FAIL preempt_follow: seen=%0d edges=%0d vec=%0d expected 1 1 6", seen, edges, cpu_if.int_vector);
        end
        ack_pulse();
        done_pulse();
        buttons = 4'b0000;
        repeat (12) step();
    endtask

    task automatic test_reset_in_service();
        int edges;
        bit seen;
        bit any_req = 0;
        write_mask(4'b0111);
        buttons = 4'b0101;
        wait_req(20, edges, seen);
        repeat (3) step();
        ack_pulse();
        checks++;
        if (!seen || fsm_state !== 2'b10 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL service_setup: seen=%0d state=%b pending=%b expected 1 10 0100", seen, fsm_state, pending);
        end
        reset = 1'b0;
        buttons = 4'b0000;
        step();
        checks++;
        if (cpu_if.int_req !== 1'b0 || cpu_if.interruptions !== 8'h00 || cpu_if.int_vector !== 3'd0 ||
            pending !== 4'b0000 || mask !== 4'b1111 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_abort: req=%b intr=%h vec=%0d pending=%b mask=%b state=%b", cpu_if.int_req, cpu_if.interruptions, cpu_if.int_vector, pending, mask, fsm_state);
        end
        reset = 1'b1;
        repeat (15) begin
            step();
            if (cpu_if.int_req === 1'b1) any_req = 1;
        end
        checks++;
        if (any_req || pending !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_quiet: req_seen=%0d pending=%b expected 0 0000", any_req, pending);
        end
    endtask

    task automatic test_random();
        int hold[4] = '{0, 0, 0, 0};
        reset = 1'b0;
        buttons = 4'b0000;
        step();
        reset = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            checks++;
            if (pending !== m_pend || mask !== m_mask) begin
                errors++;
                $display("FAIL rand_regs cyc %0d: pending=%b mask=%b expected %b %b", cyc, pending, mask, m_pend, m_mask);
            end
            checks++;
            if (cpu_if.int_req !== m_req || cpu_if.interruptions !== m_intr ||
                (m_req && cpu_if.int_vector !== m_vec)) begin
                errors++;
                $display("FAIL rand_cpu cyc %0d: req=%b vec=%0d intr=%h expected %b %0d %h", cyc, cpu_if.int_req, cpu_if.int_vector, cpu_if.interruptions, m_req, m_vec, m_intr);
            end
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    buttons[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 10);
                end else begin
                    hold[i]--;
                end
            end
            mask_we = ($urandom_range(0, 15) == 0);
            mask_in = 4'($urandom);
            cpu_if.int_ack  = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            cpu_if.int_done = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
        end
        cpu_if.int_ack = 1'b0;
        cpu_if.int_done = 1'b0;
        mask_we = 1'b0;
    endtask

    initial begin
        cpu_if.int_ack = 1'b0;
        cpu_if.int_done = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_priority();
        test_mask();
        test_no_preempt();
        test_reset_in_service();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences the button interrupt sources feeding the I/O manager and presents one prioritised request at a time to the CPU.
- Synchronises and debounces the 4 raw push-buttons and latches rising edges as pending events.
- Applies a CPU-writable mask, then runs a request/acknowledge/service handshake.
- Drives the 8-bit `interruptions` bus in the same bit mapping the I/O manager uses: button0→bit6, button1→bit5, button2→bit4, button3→bit3.

Parameters:
- N_SRC, 4, number of button sources; fixed mapping above valid only for 4.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before a synchronised input change is accepted; minimum 2.
- CNT_W, 5, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- buttons  input  4  raw asynchronous push-buttons, active-high.
- mask_we  input  1  write strobe for mask register.
- mask_in  input  4  new mask value; bit i=1 enables source i.
- int_ack  input  1  CPU accepts current request (1-cycle pulse).
- int_done  input  1  CPU finished handler (1-cycle pulse).
- int_req  output  1  interrupt request to CPU.
- int_vector  output  3  interruptions bit index of the active source: 6, 5, 4 or 3.
- pending  output  4  latched, not yet acknowledged events.
- mask  output  4  current mask register.
- interruptions  output  8  one-hot of the active source at its mapped bit while int_req or in SERVICE; otherwise 0.

Behaviour:
- Reset: on any edge with reset=0, all of these clear:
  - synchronisers, debounced levels and counters;
  - pending=0, mask=4'b1111, int_req=0, int_vector=0, interruptions=0;
  - FSM=IDLE.
  - Reset asserted mid-handshake aborts it; no events survive.
- Input path, per source:
  - Two-flop synchroniser.
  - Counter increments each edge the synchronised value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on that edge and the counter clears.
- Event capture: a debounced 0→1 transition sets pending[i] on the next edge. Falling edges are ignored.
- Mask:
  - mask_we loads mask_in on the edge.
  - Masked sources still latch pending. They are just not selected.
  - Unmasking a pending source makes it eligible the next cycle.
- Priority: lowest index wins; button0 is highest.
- FSM:
  - IDLE:
    - If (pending & mask)≠0, latch the winning index into `sel`.
    - Set int_req=1 and int_vector/interruptions for `sel` on the same edge; go to REQUEST.
  - REQUEST:
    - Hold int_req=1 and `sel` stable. Mask changes and new higher-priority events do not preempt.
    - On int_ack=1: clear pending[sel], int_req→0, go to SERVICE.
  - SERVICE:
    - interruptions stays showing `sel`. No new request is issued; no nesting.
    - On int_done=1: interruptions→0, go to IDLE.
    - A new request may be raised on the edge after IDLE is re-entered.
- Spurious handshakes:
  - int_ack outside REQUEST is ignored.
  - int_done outside SERVICE is ignored.
  - int_ack and int_done in the same cycle: only the one valid for the current state acts.
- Set/clear collision: if the pending[sel] set event and its ack clear fall on the same edge, set wins (the new event stays pending).
- Repeated press: a press on a source that is already pending is merged (single pending bit, no counter).
- Latency: from raw button rising and staying high, int_req asserts DEBOUNCE_CYCLES+4 edges later in IDLE with no higher-priority contention:
  - 2 edges synchroniser;
  - DEBOUNCE_CYCLES edges debounce;
  - 1 edge pending;
  - 1 edge request.

Decomposition:
- Shared package `io_pkg`:
  - FSM state encoding: IDLE=2'b00, REQUEST=2'b01, SERVICE=2'b10.
  - Button→interruptions bit map constants: INT_BIT_BTN0..3 = 6, 5, 4, 3.
  - Default mask constant.
- One sub-module `button_debouncer`: synchroniser, counter and debounced level for one source, parameterised by DEBOUNCE_CYCLES/CNT_W. Instantiated N_SRC times.
- Capture, mask, priority and FSM stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset=0 for 2 edges with buttons=4'b1111 → all outputs 0, mask=4'b1111. After release and buttons held, int_req rises exactly 8 edges after button0's rise (int_vector=6, interruptions=8'h40).
- button1 glitch high 3 cycles then low → pending stays 0, int_req never asserts.
- buttons 4'b1010 rise together → int_vector=5 (btn1) first. ack then done → next request int_vector=3 (btn3) one edge after IDLE.
- mask_in=4'b1110, button0 pressed → pending=4'b0001, int_req=0. Then mask_in=4'b1111 → int_req=1 next edge, vector 6.
- In REQUEST with sel=btn2, press btn0 → int_vector stays 4 until ack. After done, btn0 is served. int_done issued in REQUEST is ignored.
- Reset=0 asserted in SERVICE with pending=4'b0100 → next edge all clear, FSM IDLE, no request after reset release.
